// File: rtl/mem_control.sv
// mem_control: arbitrates a fetch port and a data port onto one 16-bit SRAM.
// Each 32-bit word is two halfwords, stored big-endian (high half at the even
// halfword address). The data port always wins over fetch. A transaction takes
// three cycles after it is accepted: HI, LO, DONE.
//
// Ports:
//   clock, reset          - clock; asynchronous active-low reset
//   if_mc_*  / mc_if_*    - fetch request/response (word address, data, valid, stall)
//   mem_mc_* / mc_mem_*   - data-port request/response (rw, address, wdata, rdata, done)
//   mc_ram_* / ram_mc_*   - SRAM halfword address, write enable, write/read data
module mem_control (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_mc_en,
    input  logic [31:0] if_mc_addr,
    output logic [31:0] mc_if_data,
    output logic        mc_if_valid,
    output logic        mc_if_stall,
    input  logic        mem_mc_en,
    input  logic        mem_mc_rw,
    input  logic [31:0] mem_mc_addr,
    input  logic [31:0] mem_mc_wdata,
    output logic [31:0] mc_mem_rdata,
    output logic        mc_mem_done,
    output logic [17:0] mc_ram_addr,
    output logic        mc_ram_we,
    output logic [15:0] mc_ram_wdata,
    input  logic [15:0] ram_mc_rdata
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned RAM_AW = 18;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] F_HI = 3'd1;
    localparam logic [2:0] F_LO = 3'd2;
    localparam logic [2:0] M_HI = 3'd3;
    localparam logic [2:0] M_LO = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

    logic [2:0]        state_q,     state_d;
    logic [RAM_AW-1:0] base_q,      base_d;
    logic              rw_q,        rw_d;
    logic [WORD_W-1:0] wdata_q,     wdata_d;
    logic [HALF_W-1:0] hi_q,        hi_d;
    logic [WORD_W-1:0] if_data_q,   if_data_d;
    logic              if_valid_q,  if_valid_d;
    logic [WORD_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              mem_done_q,  mem_done_d;

    // Address bits outside [18:1] do not select SRAM storage.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_mc_addr[31:19], if_mc_addr[0],
                                mem_mc_addr[31:19], mem_mc_addr[0]};

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            rw_q        <= 1'b0;
            wdata_q     <= '0;
            hi_q        <= '0;
            if_data_q   <= '0;
            if_valid_q  <= 1'b0;
            mem_rdata_q <= '0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            rw_q        <= rw_d;
            wdata_q     <= wdata_d;
            hi_q        <= hi_d;
            if_data_q   <= if_data_d;
            if_valid_q  <= if_valid_d;
            mem_rdata_q <= mem_rdata_d;
            mem_done_q  <= mem_done_d;
        end
    end

    // Next-state and register updates.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        rw_d        = rw_q;
        wdata_d     = wdata_q;
        hi_d        = hi_q;
        if_data_d   = if_data_q;
        if_valid_d  = 1'b0;
        mem_rdata_d = mem_rdata_q;
        mem_done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_mc_en) begin
                    state_d = M_HI;
                    base_d  = mem_mc_addr[18:1];
                    rw_d    = mem_mc_rw;
                    wdata_d = mem_mc_wdata;
                end else if (if_mc_en) begin
                    state_d = F_HI;
                    base_d  = if_mc_addr[18:1];
                    rw_d    = 1'b0;
                    wdata_d = '0;
                end
            end
            F_HI: begin
                hi_d    = ram_mc_rdata;
                state_d = F_LO;
            end
            F_LO: begin
                if_data_d  = {hi_q, ram_mc_rdata};
                if_valid_d = 1'b1;
                state_d    = DONE;
            end
            M_HI: begin
                hi_d    = ram_mc_rdata;
                state_d = M_LO;
            end
            M_LO: begin
                if (!rw_q) begin
                    mem_rdata_d = {hi_q, ram_mc_rdata};
                end
                mem_done_d = 1'b1;
                state_d    = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // SRAM drive is decoded from the state register so reset removes it at once.
    always_comb begin
        mc_ram_addr  = '0;
        mc_ram_we    = 1'b0;
        mc_ram_wdata = '0;
        case (state_q)
            F_HI: mc_ram_addr = base_q;
            F_LO: mc_ram_addr = base_q + RAM_AW'(1);
            M_HI: begin
                mc_ram_addr = base_q;
                if (rw_q) begin
                    mc_ram_we    = 1'b1;
                    mc_ram_wdata = wdata_q[31:16];
                end
            end
            M_LO: begin
                mc_ram_addr = base_q + RAM_AW'(1);
                if (rw_q) begin
                    mc_ram_we    = 1'b1;
                    mc_ram_wdata = wdata_q[15:0];
                end
            end
            default: ;
        endcase
    end

    assign mc_if_data   = if_data_q;
    assign mc_if_valid  = if_valid_q;
    assign mc_mem_rdata = mem_rdata_q;
    assign mc_mem_done  = mem_done_q;
    assign mc_if_stall  = if_mc_en & ~if_valid_q;

endmodule

// File: doc/mem_control.md
MEM_CONTROL -- requirements
Module: mem_control

Interface
REQ-001 SHALL have port clock, input, 1 bit: single clock; all state changes on posedge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port if_mc_en, input, 1 bit: fetch read request, level, held until mc_if_valid.
REQ-004 SHALL have port if_mc_addr, input, 32 bits: fetch byte address; bit 0 ignored.
REQ-005 SHALL have port mc_if_data, output, 32 bits: fetched word, registered.
REQ-006 SHALL have port mc_if_valid, output, 1 bit: one-cycle pulse, mc_if_data valid.
REQ-007 SHALL have port mc_if_stall, output, 1 bit: combinational, equal to if_mc_en AND NOT mc_if_valid.
REQ-008 SHALL have port mem_mc_en, input, 1 bit: data-port request, level, held until mc_mem_done.
REQ-009 SHALL have port mem_mc_rw, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port mem_mc_addr, input, 32 bits: data byte address; bit 0 ignored.
REQ-011 SHALL have port mem_mc_wdata, input, 32 bits: write word.
REQ-012 SHALL have port mc_mem_rdata, output, 32 bits: read word, registered.
REQ-013 SHALL have port mc_mem_done, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have port mc_ram_addr, output, 18 bits: SRAM halfword address.
REQ-015 SHALL have port mc_ram_we, output, 1 bit: SRAM write enable, active high.
REQ-016 SHALL have port mc_ram_wdata, output, 16 bits: SRAM write halfword.
REQ-017 SHALL have port ram_mc_rdata, input, 16 bits: SRAM read halfword, combinational, valid in the same cycle as the address.

Function
REQ-018 SHALL implement the states IDLE, F_HI, F_LO, M_HI, M_LO and DONE.
REQ-019 In IDLE, SHALL go to M_HI when mem_mc_en=1, else to F_HI when if_mc_en=1, else stay in IDLE; the data port always has priority over fetch.
REQ-020 On leaving IDLE, SHALL latch the address, rw and wdata of the granted port; later input changes SHALL NOT affect the transaction in progress.
REQ-021 SHALL set the base halfword address to latched addr[18:1]; bits 31:19 SHALL be ignored.
REQ-022 In F_HI and M_HI, SHALL drive mc_ram_addr to the base address and SHALL capture ram_mc_rdata into the high-half register at the cycle-end edge.
REQ-023 In F_LO and M_LO, SHALL drive mc_ram_addr to base+1 modulo 2^18 (base 18'h3FFFF wraps to 0).
REQ-024 SHALL store words big-endian: bits 31:16 at the base address, bits 15:0 at base+1.
REQ-025 At the F_LO exit edge, SHALL load {high register, ram_mc_rdata} into mc_if_data.
REQ-026 At the M_LO exit edge for a read, SHALL load {high register, ram_mc_rdata} into mc_mem_rdata.
REQ-027 For a write, SHALL drive mc_ram_we=1 in M_HI with wdata[31:16] and in M_LO with wdata[15:0].
REQ-028 mc_ram_we SHALL be 0 in every other state.
REQ-029 DONE SHALL last one cycle, assert mc_if_valid or mc_mem_done for the served port only, and then go to IDLE.
REQ-030 SHALL take no new request in DONE, so the next request is accepted in IDLE one cycle later.
REQ-031 Latency SHALL be: request accepted at edge N, then F_HI/M_HI in cycle N+1, LO in cycle N+2, and the valid/done pulse plus data in cycle N+3.
REQ-032 If a requester drops its enable mid-transaction, SHALL still complete the transaction: the write is performed and the pulse is still issued.
REQ-033 If both enables are set in IDLE, SHALL serve the data port first; fetch SHALL stay stalled and be served next, with no starvation check required.
REQ-034 mc_if_data and mc_mem_rdata SHALL hold their values until overwritten by a completion on the same port.
REQ-035 When not writing, mc_ram_wdata SHALL be 16'h0000.
REQ-036 When in IDLE or DONE, mc_ram_addr SHALL be 18'h0.

Reset
REQ-037 On reset=0, SHALL immediately, without waiting for a clock edge, force state IDLE and clear all outputs and internal registers: mc_ram_we=0, pulses 0, data 0.
REQ-038 A reset during any transaction SHALL abort it with no pulse and no further SRAM write; the requester SHALL re-issue after reset.
REQ-039 After reset is released, the first accept SHALL occur at the first posedge with an enable high.

Verification
REQ-040 Fetch: preload SRAM[0x10]=16'h1234, [0x11]=16'h5678; set if_mc_en=1 with addr 0x20 -> mc_if_data=32'h12345678 with mc_if_valid high exactly 3 cycles after accept, and mc_if_stall high until then.
REQ-041 Write then read: write addr 0x40 data 32'hDEADBEEF -> SRAM[0x20]=16'hDEAD and [0x21]=16'hBEEF with mc_ram_we high for exactly 2 cycles; a read of the same address then returns 32'hDEADBEEF.
REQ-042 Priority: assert both enables in the same cycle -> the data transaction completes first, and the fetch completes 4 cycles later.
REQ-043 Wrap: fetch addr 0x7FFFE -> mc_ram_addr=18'h3FFFF and then 18'h00000.
REQ-044 Reset in M_LO of a write -> mc_ram_we drops immediately, SRAM[base+1] is unchanged, no mc_mem_done pulse, and the state is IDLE.
REQ-045 Enable dropped in F_HI -> the transaction completes and mc_if_valid pulses once.
